// File: rtl/receiver.sv
// Asynchronous serial receiver: 8 data bits LSB first, one start bit,
// one stop bit, with an optional even-parity bit.
// Mid-bit sampling is driven by a baud counter of CLK_FREQ/BAUD cycles.
// Optional feature macro: RX_PARITY_EN adds the even-parity bit, the
// PARITY state and the parity_err port.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         raw serial line (idle high)
//   data       last correctly received byte
//   rx_done    one-cycle pulse, data updated with a good frame
//   frame_err  one-cycle pulse, stop bit sampled low
//   parity_err one-cycle pulse, parity mismatch (RX_PARITY_EN only)
module receiver #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_done,
   output logic       frame_err
`ifdef RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
   localparam int unsigned HALF_CNT = BIT_CNT / 2;
   localparam int unsigned CNT_W    = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state, state_n;
   logic             rx_meta, rx_s, rx_prev;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       data_n;
   logic             rx_done_n, frame_err_n;
   logic             par_bad;
`ifdef RX_PARITY_EN
   logic             par_bit, par_bit_n;
   logic             parity_err_n;
   assign par_bad = ^{shift, par_bit};
`else
   assign par_bad = 1'b0;
`endif

   // Synchronizer plus one-cycle history of rx_s for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
`ifdef RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         data      <= data_n;
         rx_done   <= rx_done_n;
         frame_err <= frame_err_n;
`ifdef RX_PARITY_EN
         par_bit    <= par_bit_n;
         parity_err <= parity_err_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift;
      data_n      = data;
      rx_done_n   = 1'b0;
      frame_err_n = 1'b0;
`ifdef RX_PARITY_EN
      par_bit_n    = par_bit;
      parity_err_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            // Only a real high-to-low transition starts a frame, so a held
            // low line (break) never retriggers.
            if (rx_prev && !rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n     = '0;
               shift_n   = {rx_s, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_n     = '0;
               par_bit_n = rx_s;
               state_n   = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            // Leave mid-stop-bit so a following start bit is caught.
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (!rx_s) begin
                  frame_err_n = 1'b1;
               end else if (par_bad) begin
`ifdef RX_PARITY_EN
                  parity_err_n = 1'b1;
`endif
               end else begin
                  data_n    = shift;
                  rx_done_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver at default parameters (434 clocks/bit).
// A frame-level reference model predicts which frames are accepted and the
// resulting data/pulse counts; monitors record what the DUT produced.
module tb_receiver;

   localparam int unsigned BIT  = 50_000_000 / 115200;
   localparam int unsigned HALF = BIT / 2;
`ifdef RX_PARITY_EN
   localparam int unsigned LAT = HALF + 10 * BIT;
`else
   localparam int unsigned LAT = HALF + 9 * BIT;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;

   receiver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .rx_done   (rx_done),
      .frame_err (frame_err)
`ifdef RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );
`ifndef RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #10 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   // Observed activity
   int          done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, multi = 0;
   int unsigned last_done_cyc = 0;
   logic        prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
   logic [7:0]  got_q[$];

   // Reference model state
   int          exp_done = 0, exp_ferr = 0, exp_perr = 0;
   logic [7:0]  exp_data = 8'h00;
   logic [7:0]  exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt++;
         got_q.push_back(data);
         last_done_cyc = cyc;
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if ((rx_done && prev_done) || (frame_err && prev_ferr) || (parity_err && prev_perr))
         multi++;
      prev_done = rx_done;
      prev_ferr = frame_err;
      prev_perr = parity_err;
   end

   initial begin
      repeat (98000) @(posedge clk);
      $display("FAIL watchdog cycles=%0d expected completion before 98000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; rx is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
      rx = 1'b0;
      wait_cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cycles(BIT);
      end
`ifdef RX_PARITY_EN
      rx = par;
      wait_cycles(BIT);
`endif
      rx = stop;
      wait_cycles(BIT);
   endtask

   // Frame-level acceptance rules
   task automatic model(input logic [7:0] b, input logic stop, input logic par);
      if (!stop) exp_ferr++;
`ifdef RX_PARITY_EN
      else if (par != ^b) exp_perr++;
`endif
      else begin
         exp_done++;
         exp_data = b;
         exp_q.push_back(b);
      end
   endtask

   task automatic send_and_model(input logic [7:0] b, input logic stop, input logic par);
      send_frame(b, stop, par);
      model(b, stop, par);
   endtask

   task automatic check_all(input string tag);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
      check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(exp_ferr));
      check({tag, "_perr_cnt"}, 32'(perr_cnt), 32'(exp_perr));
      check({tag, "_data"}, 32'(data), 32'(exp_data));
      check({tag, "_multi"}, 32'(multi), 32'd0);
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0]  b;
      logic        stop, par;
      int unsigned c0, lat;

      // Reset state
      #35;
      check("rst_data", 32'(data), 32'h00);
      check("rst_done", 32'(rx_done), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_perr", 32'(parity_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_cycles(20);

      // Single frame plus latency from start edge to rx_done
      c0 = cyc;
      send_and_model(8'hD3, 1'b1, ^8'hD3);
      wait_cycles(BIT);
      check_all("d3");
      lat = last_done_cyc - c0;
      check("d3_latency_window", 32'((lat >= LAT) && (lat <= LAT + 4)), 32'd1);

      // Back-to-back frames
      send_and_model(8'hD3, 1'b1, ^8'hD3);
      send_and_model(8'h3A, 1'b1, ^8'h3A);
      wait_cycles(BIT);
      check_all("b2b");

      // Short glitch is a false start
      rx = 1'b0;
      wait_cycles(100);
      rx = 1'b1;
      wait_cycles(BIT);
      check_all("glitch");

      // Framing error
      send_and_model(8'h55, 1'b0, ^8'h55);
      rx = 1'b1;
      wait_cycles(BIT);
      check_all("ferr");

      // Break: line stays low after a framing error, then recovers
      send_and_model(8'h81, 1'b0, ^8'h81);
      wait_cycles(3 * BIT);
      rx = 1'b1;
      wait_cycles(BIT);
      check_all("break");
      send_and_model(8'h6E, 1'b1, ^8'h6E);
      wait_cycles(BIT);
      check_all("after_break");

      // Reset in the middle of bit 4 of 8'h3C
      b = 8'h3C;
      rx = 1'b0;
      wait_cycles(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         wait_cycles(BIT);
      end
      rx = b[4];
      wait_cycles(HALF);
      rst_n = 1'b0;
      #2;
      exp_data = 8'h00;
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_done", 32'(rx_done), 32'd0);
      check("midrst_ferr", 32'(frame_err), 32'd0);
      wait_cycles(5);
      rst_n = 1'b1;
      rx = 1'b1;
      wait_cycles(2 * BIT);
      check_all("midrst_quiet");
      send_and_model(8'hA5, 1'b1, ^8'hA5);
      wait_cycles(BIT);
      check_all("a5");

      // Randomized frames with random gaps, stop errors and parity errors
      for (int n = 0; n < 4; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         par  = (^b) ^ ($urandom_range(0, 3) == 0);
         send_and_model(b, stop, par);
         rx = 1'b1;
         wait_cycles(stop ? $urandom_range(0, 40) : 10 + $urandom_range(0, 40));
      end
      wait_cycles(BIT);
      check_all("random");

`ifdef RX_PARITY_EN
      // Even parity: 8'h07 needs parity bit 1
      send_and_model(8'h07, 1'b1, 1'b1);
      wait_cycles(BIT);
      check_all("par_good");
      send_and_model(8'h07, 1'b1, 1'b0);
      wait_cycles(BIT);
      check_all("par_bad");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
